muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multiply/divide unit for the E stage of the five-stage pipeline, holding the architectural HI/LO registers. It accepts one operation per start pulse, computes over a fixed, parameter-set latency with a busy flag for the stall logic, and commits HI/LO atomically at completion. It adds MTHI/MTLO, signed and unsigned ops, and optional multiply-accumulate to the current datapath.

## Interface
- DATA_W, 32, operand/HI/LO width (≥ 8)
- MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD/MADDU (≥ 1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥ 1)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  operation request, sampled at rising edge
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
- a  in  DATA_W  operand A (rs value, forwarded)
- b  in  DATA_W  operand B (rt value, forwarded)
- busy  out  1  computation in progress
- done  out  1  one-cycle pulse after HI/LO commit of a timed op
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register

## Operation
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, counter=0, shadow result=0.
- Idle (busy=0) and start=1:
  - MTHI: hi<=a at that edge. MTLO: lo<=a. busy stays 0, done stays 0.
  - MULT/MULTU: 2·DATA_W product of a×b, signed or unsigned, goes to the shadow register. Counter is loaded with MULT_CYCLES.
  - DIV/DIVU: quotient goes to shadow-lo and remainder to shadow-hi. Counter is loaded with DIV_CYCLES.
  - Signed division truncates toward zero. The remainder takes the sign of the dividend.
  - Divide by zero (b=0), signed or unsigned: shadow-hi=a, shadow-lo=all ones. No error is flagged.
  - Signed overflow (a = most-negative, b = −1): shadow-lo=a, shadow-hi=0.
  - MADD/MADDU (macro enabled only): shadow={hi,lo} + a×b, signed or unsigned, modulo 2^(2·DATA_W). Product and sum use hi/lo as they are at the start edge.
- States: IDLE (counter=0) → BUSY (counter>0). The counter decrements each edge. At the edge where it goes 1→0: {hi,lo}<=shadow, done<=1, return to IDLE.
- busy = (counter≠0), registered.
- Operands are latched at the start edge. Changes on a/b/op afterwards have no effect.
- start while busy=1 is ignored entirely: no restart, no MTHI/MTLO write. The stall logic prevents this case; the block does not rely on it.
- hi/lo show the old values for the whole busy window. They never show partial results.
- start on the same edge busy falls (counter 1→0) is ignored, because busy=1 at that edge.
- Reset mid-operation aborts the op. HI/LO go to 0, not to the pending result.

## Timing
- Start accepted at edge T0. busy=1 during cycles T0+1 … T0+N, where N = MULT_CYCLES or DIV_CYCLES.
- hi/lo take the new value and done=1 in cycle T0+N+1.
- busy=0 in cycle T0+N+1. A new start is accepted at the edge ending cycle T0+N+1.
- MTHI/MTLO: new value visible in cycle T0+1. Zero latency for back-to-back MT ops.
- The hazard unit stalls D when an MFHI/MFLO/mul-div instruction is in D and (E start | busy). That logic is outside this block.

## Configuration
- MULDIV_MADD_EN defined: op 6/7 perform MADD/MADDU with MULT_CYCLES latency.
- MULDIV_MADD_EN undefined: op 6/7 with start=1 are no-ops. busy, done, hi and lo are unchanged, and no accumulator adder is synthesised.

## Test plan
- Reset, then MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive edges. Required: hi=0x12345678 and lo=0x9ABCDEF0 one cycle after each write; busy never rises.
- MULT a=0xFFFFFFFE (−2), b=3 (DATA_W=32, MULT_CYCLES=5). Required: busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse of 1 cycle. MULTU with the same operands: hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=−7 (0xFFFFFFF9), b=2. Required: after 10 busy cycles, lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=7, b=0: hi=7, lo=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF. Required: lo=0x80000000, hi=0.
- During a DIV busy window, assert start with MTLO a=5 and with MULT. Required: both ignored, completion cycle unchanged. Assert reset at busy cycle 4: hi=lo=0 and busy=0 immediately; done never pulses.
- With MULDIV_MADD_EN, hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1. Required: hi=1, lo=0 after 5 cycles. Without the macro: the same stimulus leaves hi=0, lo=0xFFFFFFFF, busy=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit holding HI/LO, committed atomically on completion.
// Define MULDIV_MADD_EN to enable MADD/MADDU (ops 6/7); otherwise those ops are no-ops.
module muldiv_unit #(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int W2   = 2 * DATA_W;
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  typedef enum logic {IDLE, BUSY} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]     shadow_q, shadow_d;
  logic [DATA_W-1:0] hi_d, lo_d;
  logic              done_d;
  logic              sgn, a_neg, b_neg;
  logic [W2-1:0]     a_ext, b_ext, prod, div_res;
  logic [DATA_W-1:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
  // Even opcodes are the signed variants; odd are unsigned.
  assign sgn   = ~op[0];
  assign a_neg = sgn & a[DATA_W-1];
  assign b_neg = sgn & b[DATA_W-1];
  assign a_ext = {{DATA_W{a_neg}}, a};
  assign b_ext = {{DATA_W{b_neg}}, b};
  assign prod  = a_ext * b_ext;
  // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend.
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
  assign r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
  assign quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;
  assign div_res = (b == '0) ? {a, {DATA_W{1'b1}}} :
                   (sgn && a == MOST_NEG && b == {DATA_W{1'b1}}) ? {{DATA_W{1'b0}}, a} :
                   {rem, quo};
  assign busy = (state_q == BUSY);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    hi_d     = hi;
    lo_d     = lo;
    done_d   = 1'b0;
    if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        {hi_d, lo_d} = shadow_q;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
    end else if (start) begin
      case (op)
        3'd0, 3'd1: begin
          shadow_d = prod;
          cnt_d    = CW'(MULT_CYCLES);
          state_d  = BUSY;
        end
        3'd2, 3'd3: begin
          shadow_d = div_res;
          cnt_d    = CW'(DIV_CYCLES);
          state_d  = BUSY;
        end
        3'd4: hi_d = a;
        3'd5: lo_d = a;
`ifdef MULDIV_MADD_EN
        default: begin
          shadow_d = {hi, lo} + prod;
          cnt_d    = CW'(MULT_CYCLES);
          state_d  = BUSY;
        end
`else
        default: ;
`endif
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      hi       <= hi_d;
      lo       <= lo_d;
      done     <= done_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed stimulus checked every cycle against a schedule-based model.
module tb_muldiv_unit;
  localparam int DW = 32;
  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MULDIV_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          reset, start;
  logic [2:0]    op;
  logic [DW-1:0] a, b;
  logic          busy, done;
  logic [DW-1:0] hi, lo;
  muldiv_unit #(.DATA_W(DW), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] m_hi = '0, m_lo = '0;
  logic [63:0]   m_res = '0;
  logic          m_done = 1'b0;
  int            commit_at = -1;
  int            edge_n = 0;
  logic          lit_on = 1'b0, lit_dut = 1'b0;
  logic [63:0]   lit_act = '0, lit_exp = '0;
  string         lit_name = "";
  function automatic logic [63:0] result(input logic [2:0] o, input logic [31:0] x, y, hh, ll);
    int sx, sy, q, r;
    sx = x;
    sy = y;
    case (o)
      3'd0: return longint'(sx) * longint'(sy);
      3'd1: return 64'(x) * 64'(y);
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
        q = sx / sy;
        r = sx % sy;
        return {r, q};
      end
      3'd3: return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      3'd6: return {hh, ll} + 64'(longint'(sx) * longint'(sy));
      default: return {hh, ll} + 64'(x) * 64'(y);
    endcase
  endfunction
  // Model: an accepted timed op schedules its commit N edges later; until then every start is ignored.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= '0; m_lo <= '0; m_done <= 1'b0; commit_at <= -1; m_res <= '0;
    end else begin
      edge_n <= edge_n + 1;
      m_done <= 1'b0;
      if (commit_at >= 0) begin
        if (commit_at == edge_n + 1) begin
          {m_hi, m_lo} <= m_res; m_done <= 1'b1; commit_at <= -1;
        end
      end else if (start) begin
        if (op == 3'd4) m_hi <= a;
        else if (op == 3'd5) m_lo <= a;
        else if (op < 3'd4 || MADD) begin
          m_res     <= result(op, a, b, m_hi, m_lo);
          commit_at <= edge_n + 1 + ((op == 3'd2 || op == 3'd3) ? DC : MC);
        end
      end
    end
  end
  always @(negedge clk) begin
    vectors++;
    if ({busy, done, hi, lo} !== {commit_at >= 0, m_done, m_hi, m_lo}) begin
      miscompares++;
      $display("FAIL cycle t=%0t busy/done/hi/lo got %b/%b/%h/%h want %b/%b/%h/%h",
               $time, busy, done, hi, lo, commit_at >= 0, m_done, m_hi, m_lo);
    end
    if (lit_on) begin
      vectors++;
      if ((lit_dut ? {hi, lo} : lit_act) !== lit_exp) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", lit_name, lit_dut ? {hi, lo} : lit_act, lit_exp);
      end
    end
  end
  task automatic check(input string nm, input bit use_dut, input logic [63:0] act, exp);
    lit_name = nm; lit_dut = use_dut; lit_act = act; lit_exp = exp; lit_on = 1'b1;
    @(negedge clk);
    #1 lit_on = 1'b0;
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] x, y);
    @(posedge clk);
    #1 start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask
  task automatic wait_idle(output int n, input bit inject);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
      if (inject && n == 2) begin start = 1'b1; op = 3'd5; a = 32'd5; end
      else if (inject && n == 3) begin op = 3'd0; a = 32'd3; b = 32'd3; end
      else if (inject && n == 4) start = 1'b0;
    end
  endtask
  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int n;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    check("reset hi/lo", 1'b1, 64'h0, 64'h0);
    issue(3'd4, 32'h1234_5678, 32'h0);
    issue(3'd5, 32'h9ABC_DEF0, 32'h0);
    wait_idle(n, 1'b0);
    check("mt busy cycles", 1'b0, 64'(n), 64'd0);
    check("mthi/mtlo", 1'b1, 64'h0, 64'h1234_5678_9ABC_DEF0);
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n, 1'b0);
    check("mult busy cycles", 1'b0, 64'(n), 64'd5);
    check("mult -2*3", 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n, 1'b0);
    check("multu", 1'b1, 64'h0, 64'h0000_0002_FFFF_FFFA);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n, 1'b0);
    check("div busy cycles", 1'b0, 64'(n), 64'd10);
    check("div -7/2", 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd3, 32'd7, 32'd0);
    wait_idle(n, 1'b0);
    check("divu by zero", 1'b1, 64'h0, 64'h0000_0007_FFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n, 1'b0);
    check("div overflow", 1'b1, 64'h0, 64'h0000_0000_8000_0000);
    issue(3'd2, 32'd100, 32'd7);
    wait_idle(n, 1'b1);
    check("div with ignored starts", 1'b0, 64'(n), 64'd10);
    check("div 100/7", 1'b1, 64'h0, 64'h0000_0002_0000_000E);
    issue(3'd3, 32'd50, 32'd3);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("reset mid-op", 1'b1, 64'h0, 64'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (15) @(negedge clk);
    check("after abort", 1'b1, 64'h0, 64'h0);
    issue(3'd4, 32'h0, 32'h0);
    issue(3'd5, 32'hFFFF_FFFF, 32'h0);
    issue(3'd7, 32'd1, 32'd1);
    wait_idle(n, 1'b0);
`ifdef MULDIV_MADD_EN
    check("maddu busy cycles", 1'b0, 64'(n), 64'd5);
    check("maddu carry", 1'b1, 64'h0, 64'h0000_0001_0000_0000);
`else
    check("maddu disabled busy", 1'b0, 64'(n), 64'd0);
    check("maddu disabled", 1'b1, 64'h0, 64'h0000_0000_FFFF_FFFF);
`endif
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1 start = ($urandom % 3) == 0; op = 3'($urandom); a = pick(); b = pick();
    end
    #1 start = 1'b0;
    wait_idle(n, 1'b0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
